// File: rtl/multiplier_4x4_if.sv
// rtl/multiplier_4x4_if.sv - operand/product bundle for the 4x4 unsigned multiplier
interface multiplier_4x4_if;
  logic in_valid;
  logic A0, A1, A2, A3;
  logic B0, B1, B2, B3;
  logic P0, P1, P2, P3, P4, P5, P6, P7;
  logic out_valid;

  modport master (
    output in_valid, A0, A1, A2, A3, B0, B1, B2, B3,
    input  P0, P1, P2, P3, P4, P5, P6, P7, out_valid
  );

  modport slave (
    input  in_valid, A0, A1, A2, A3, B0, B1, B2, B3,
    output P0, P1, P2, P3, P4, P5, P6, P7, out_valid
  );
endinterface

// File: rtl/multiplier_4x4.sv
// rtl/multiplier_4x4.sv - registered 4x4 unsigned array multiplier
// Define MULTIPLIER_PIPE_EN to register the datapath after the first adder row (latency 2).
module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;
endmodule

module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);
  assign o_s  = i_a ^ i_b ^ i_ci;
  assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));
endmodule

module multiplier_4x4 (
  input  logic             clk,
  input  logic             rst_n,
  multiplier_4x4_if.slave  bus
);
  logic [3:0] w_a, w_b;
  logic [3:0] w_pp [4];
  logic [3:0] w_col2, w_col3;

  assign w_a = {bus.A3, bus.A2, bus.A1, bus.A0};
  assign w_b = {bus.B3, bus.B2, bus.B1, bus.B0};

  // w_pp[i][j] = Ai & Bj; columns for B2/B3 feed the later rows
  for (genvar i = 0; i < 4; i++) begin : g_pp
    assign w_pp[i]   = {4{w_a[i]}} & w_b;
    assign w_col2[i] = w_pp[i][2];
    assign w_col3[i] = w_pp[i][3];
  end

  logic       w_r1_p1;
  logic [3:1] w_r1_s;
  logic [3:0] w_r1_c;

  half_adder u_r1_0 (.i_a(w_pp[1][0]), .i_b(w_pp[0][1]), .o_s(w_r1_p1), .o_c(w_r1_c[0]));
  full_adder u_r1_1 (.i_a(w_pp[2][0]), .i_b(w_pp[1][1]), .i_ci(w_r1_c[0]), .o_s(w_r1_s[1]), .o_co(w_r1_c[1]));
  full_adder u_r1_2 (.i_a(w_pp[3][0]), .i_b(w_pp[2][1]), .i_ci(w_r1_c[1]), .o_s(w_r1_s[2]), .o_co(w_r1_c[2]));
  half_adder u_r1_3 (.i_a(w_pp[3][1]), .i_b(w_r1_c[2]), .o_s(w_r1_s[3]), .o_c(w_r1_c[3]));

  logic       w_st_valid;
  logic [1:0] w_st_low;
  logic [3:0] w_st_sum, w_st_pp2, w_st_pp3;

`ifdef MULTIPLIER_PIPE_EN
  logic       r_st_valid;
  logic [1:0] r_st_low;
  logic [3:0] r_st_sum, r_st_pp2, r_st_pp3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_st_valid <= 1'b0;
      r_st_low   <= '0;
      r_st_sum   <= '0;
      r_st_pp2   <= '0;
      r_st_pp3   <= '0;
    end else begin
      r_st_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_st_low <= {w_r1_p1, w_pp[0][0]};
        r_st_sum <= {w_r1_c[3], w_r1_s[3], w_r1_s[2], w_r1_s[1]};
        r_st_pp2 <= w_col2;
        r_st_pp3 <= w_col3;
      end
    end
  end

  assign w_st_valid = r_st_valid;
  assign w_st_low   = r_st_low;
  assign w_st_sum   = r_st_sum;
  assign w_st_pp2   = r_st_pp2;
  assign w_st_pp3   = r_st_pp3;
`else
  assign w_st_valid = bus.in_valid;
  assign w_st_low   = {w_r1_p1, w_pp[0][0]};
  assign w_st_sum   = {w_r1_c[3], w_r1_s[3], w_r1_s[2], w_r1_s[1]};
  assign w_st_pp2   = w_col2;
  assign w_st_pp3   = w_col3;
`endif

  logic       w_p2, w_p3, w_p4, w_p5, w_p6, w_p7;
  logic [3:1] w_r2_s;
  logic [3:0] w_r2_c;
  logic [2:0] w_r3_c;

  half_adder u_r2_0 (.i_a(w_st_sum[0]), .i_b(w_st_pp2[0]), .o_s(w_p2), .o_c(w_r2_c[0]));
  full_adder u_r2_1 (.i_a(w_st_sum[1]), .i_b(w_st_pp2[1]), .i_ci(w_r2_c[0]), .o_s(w_r2_s[1]), .o_co(w_r2_c[1]));
  full_adder u_r2_2 (.i_a(w_st_sum[2]), .i_b(w_st_pp2[2]), .i_ci(w_r2_c[1]), .o_s(w_r2_s[2]), .o_co(w_r2_c[2]));
  full_adder u_r2_3 (.i_a(w_st_sum[3]), .i_b(w_st_pp2[3]), .i_ci(w_r2_c[2]), .o_s(w_r2_s[3]), .o_co(w_r2_c[3]));

  half_adder u_r3_0 (.i_a(w_r2_s[1]), .i_b(w_st_pp3[0]), .o_s(w_p3), .o_c(w_r3_c[0]));
  full_adder u_r3_1 (.i_a(w_r2_s[2]), .i_b(w_st_pp3[1]), .i_ci(w_r3_c[0]), .o_s(w_p4), .o_co(w_r3_c[1]));
  full_adder u_r3_2 (.i_a(w_r2_s[3]), .i_b(w_st_pp3[2]), .i_ci(w_r3_c[1]), .o_s(w_p5), .o_co(w_r3_c[2]));
  full_adder u_r3_3 (.i_a(w_r2_c[3]), .i_b(w_st_pp3[3]), .i_ci(w_r3_c[2]), .o_s(w_p6), .o_co(w_p7));

  logic [7:0] r_p;
  logic       r_out_valid;

  // product holds across idle cycles; only the valid flag drops
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_p         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_st_valid;
      if (w_st_valid) r_p <= {w_p7, w_p6, w_p5, w_p4, w_p3, w_p2, w_st_low};
    end
  end

  assign bus.P0 = r_p[0];
  assign bus.P1 = r_p[1];
  assign bus.P2 = r_p[2];
  assign bus.P3 = r_p[3];
  assign bus.P4 = r_p[4];
  assign bus.P5 = r_p[5];
  assign bus.P6 = r_p[6];
  assign bus.P7 = r_p[7];
  assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_multiplier_4x4.sv
// tb/tb_multiplier_4x4.sv - self-checking bench for multiplier_4x4 (either MULTIPLIER_PIPE_EN build)
module tb_multiplier_4x4;
`ifdef MULTIPLIER_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  multiplier_4x4_if bus ();
  multiplier_4x4 dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // reference: a delay line of LAT issued (valid, product) pairs; product holds when idle
  bit       q_v [$];
  int       q_p [$];
  int       exp_p = 0;
  bit       exp_v = 1'b0;

  function automatic logic [7:0] dut_p();
    return {bus.P7, bus.P6, bus.P5, bus.P4, bus.P3, bus.P2, bus.P1, bus.P0};
  endfunction

  task automatic drive(input bit v, input int a, input int b);
    logic [3:0] av, bv;
    av = a[3:0];
    bv = b[3:0];
    bus.in_valid = v;
    {bus.A3, bus.A2, bus.A1, bus.A0} = av;
    {bus.B3, bus.B2, bus.B1, bus.B0} = bv;
  endtask

  task automatic check(input string tag);
    logic [7:0] ep;
    ep = exp_p[7:0];
    n_cmp++;
    assert (dut_p() === ep)
      else begin n_bad++; $error("FAIL %s P observed=0x%02h expected=0x%02h", tag, dut_p(), ep); end
    n_cmp++;
    assert (bus.out_valid === exp_v)
      else begin n_bad++; $error("FAIL %s out_valid observed=%b expected=%b", tag, bus.out_valid, exp_v); end
  endtask

  task automatic step(input string tag, input bit v, input int a, input int b);
    drive(v, a, b);
    @(posedge clk);
    #1;
    q_v.push_back(v);
    q_p.push_back(a * b);
    exp_v = 1'b0;
    if (q_v.size() >= LAT) begin
      exp_v = q_v.pop_front();
      if (exp_v) exp_p = q_p.pop_front();
      else void'(q_p.pop_front());
    end
    check(tag);
  endtask

  task automatic reset_step(input string tag);
    rst_n = 1'b0;
    drive(1'b1, 15, 15);
    @(posedge clk);
    #1;
    q_v.delete();
    q_p.delete();
    exp_p = 0;
    exp_v = 1'b0;
    check(tag);
  endtask

  initial begin
    logic [7:0] pmax;
    rst_n = 1'b0;
    drive(1'b0, 0, 0);

    reset_step("reset0");
    reset_step("reset1");
    rst_n = 1'b1;
    step("post_reset_load", 1, 7, 7);
    reset_step("reset_midflight");
    rst_n = 1'b1;
    step("after_reset0", 1, 3, 5);
    for (int i = 1; i < LAT; i++) step("after_reset_lat", 0, 0, 0);
    step("after_reset_idle", 0, 0, 0);

    step("zero_a", 1, 0, 15);
    step("zero_b", 1, 15, 0);
    for (int i = 0; i < LAT; i++) step("zero_drain", 0, 9, 9);

    step("mix_6x6", 1, 6, 6);
    step("mix_2x12", 1, 2, 12);
    step("mix_9x9", 1, 9, 9);
    step("mix_8x9", 1, 8, 9);
    step("mix_10x5", 1, 10, 5);
    step("mix_5x10", 1, 5, 10);
    for (int i = 0; i < LAT; i++) step("mix_drain", 0, 0, 0);

    step("max_15x15", 1, 15, 15);
    for (int i = 1; i < LAT; i++) step("max_lat", 0, 0, 0);
    pmax = dut_p();
    n_cmp++;
    assert (pmax === 8'hE1)
      else begin n_bad++; $error("FAIL max_const P observed=0x%02h expected=0xe1", pmax); end

    step("hold_6x6", 1, 6, 6);
    for (int i = 0; i < LAT + 1; i++) step("hold_idle", 0, 15, 15);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if ($urandom_range(0, 3) == 0) step("exh_gap", 0, $urandom_range(0, 15), $urandom_range(0, 15));
        step("exh", 1, a, b);
      end
    end
    for (int i = 0; i < LAT + 1; i++) step("exh_drain", 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/multiplier_4x4.md
Name: multiplier_4x4

Overview:
- Clocked 4-bit x 4-bit unsigned multiplier with a registered 8-bit product.
- Operands and product are presented as individual scalar bit ports; bit 0 is the LSB.
- Core is a structural array of AND partial products, half adders and full adders, followed by output registers with a valid flag.
- Used as a small arithmetic leaf block inside datapaths that need an unsigned 4x4 product.

Parameters:
- None. Operand widths are fixed at 4 bits; product width is fixed at 8 bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands on A*/B* are valid this cycle
- A0  input  1  operand A bit 0 (LSB)
- A1  input  1  operand A bit 1
- A2  input  1  operand A bit 2
- A3  input  1  operand A bit 3 (MSB)
- B0  input  1  operand B bit 0 (LSB)
- B1  input  1  operand B bit 1
- B2  input  1  operand B bit 2
- B3  input  1  operand B bit 3 (MSB)
- P0..P7  output  1 each  product bits; P0 is LSB, P7 is MSB; all registered
- out_valid  output  1  P0..P7 hold a freshly computed product

Behaviour:
- Reset: reset is synchronous, active-low. On a rising clk edge with rst_n=0, P0..P7 <= 0 and out_valid <= 0. All internal pipeline registers also clear.
- Arithmetic: P = A*B, unsigned, where A={A3,A2,A1,A0} and B={B3,B2,B1,B0}.
  - Range is 0..225. No overflow is possible and no truncation is applied.
- Datapath structure:
  - 16 partial products pp[i][j] = Ai & Bj.
  - Three ripple-carry adder rows built from half_adder and full_adder submodules: 4 HA + 8 FA total, standard array-multiplier arrangement.
  - P0 = pp[0][0] directly.
  - The behavioural * operator is not used in the adder array.
- Latency (feature off): 1 cycle.
  - If in_valid=1 at edge N, then after edge N: P = product of the operands sampled at edge N, and out_valid = 1.
- Hold: if in_valid=0 at an edge, P holds its previous value and out_valid <= 0.
- Throughput: one new operand pair accepted every cycle; there is no backpressure.
- Back-to-back: consecutive valid cycles each produce their own product, in order, one per cycle.
- Reset mid-operation: any in-flight product is discarded. The first valid input after rst_n returns high gets normal latency.
- Inputs are sampled only at clk edges. Combinational glitches on A*/B* between edges have no effect on outputs.

Optional Feature:
- Macro: MULTIPLIER_PIPE_EN.
- Defined:
  - A pipeline register is inserted after the first adder row.
  - It captures partial sums, carries, the remaining partial products, P0 and P1, plus a stage-valid bit.
  - Latency becomes 2 cycles; out_valid asserts 2 edges after the in_valid edge.
  - Throughput stays 1 per cycle.
  - The stage register loads only when in_valid=1; its valid bit follows in_valid every cycle.
  - Reset clears the stage register and the stage-valid bit.
- Undefined: purely single-stage behaviour as described above (latency 1).
- Products and ordering are identical in both builds.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with A=15, B=15, in_valid=1 -> P=0x00 and out_valid=0 throughout; after rst_n=1, the next valid result appears at normal latency.
- Zero operands, in order:
  - A=0, B=15 -> P=0.
  - Then A=15, B=0 -> P=0.
  - Each with out_valid=1 at the specified latency.
- Mixed operands, streamed back-to-back one per cycle:
  - 6*6 -> 36 (0x24)
  - 2*12 -> 24
  - 9*9 -> 81
  - 8*9 -> 72
  - 10*5 -> 50
  - 5*10 -> 50
  - Check every bit P7..P0 in order, with no bubbles.
- Maximum: A=15, B=15 -> P=225 (0xE1: P7=1, P6=1, P5=1, P0=1, all others 0).
- Hold: a valid 6*6 followed by in_valid=0 while A/B change to 15/15 -> P stays 36 and out_valid drops to 0 one cycle after the valid result.
- Exhaustive: all 256 A/B pairs with random in_valid gaps -> every out_valid product matches A*B, in order. Run in both MULTIPLIER_PIPE_EN builds, with latency 1 or 2 respectively.
